// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive FSM states and the per-frame status record.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PRE,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  typedef struct packed {
    logic        ok;
    logic        crc_ok;
    logic        err;
    logic        runt;
    logic        giant;
    logic [15:0] len;
  } rx_status_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte CRC-32 step (poly 04C11DB7), bits taken LSB-first as they come off the wire.
module eth_crc32_byte (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[31] ^ data_i[i]) crc_o = {crc_o[30:0], 1'b0} ^ 32'h04C11DB7;
      else                       crc_o = {crc_o[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// RGMII byte-stream receive framer: strips preamble/SFD, forwards frame bytes without
// the FCS, and reports CRC/length/error status one cycle after the frame ends.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        rx_clk_i,
  input  logic        reset_i,
  input  logic        rx_dv_i,
  input  logic        rx_err_i,
  input  logic [7:0]  rx_data_i,
  output logic        out_valid_o,
  output logic        out_sop_o,
  output logic [7:0]  out_data_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        frame_crc_ok_o,
  output logic        frame_err_o,
  output logic        frame_runt_o,
  output logic        frame_giant_o,
  output logic [15:0] frame_len_o
);

  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  rx_state_e       state_q, state_d;
  logic [31:0]     crc_q, crc_d, crc_upd;
  logic [15:0]     len_q, len_d;
  logic            err_q, err_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic [2:0]      fill_q, fill_d;
  logic            ov_q, ov_d, sop_q, sop_d, done_q, done_d;
  logic [7:0]      od_q, od_d;
  rx_status_t      st_q, st_d;
  logic            rxe, crc_ok;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data_i),
    .crc_o  (crc_upd)
  );

  // rx_err carries DV^ER, so an error is DV high with the falling-edge sample low.
  assign rxe    = rx_dv_i & ~rx_err_i;
  assign crc_ok = (crc_q == ETH_CRC_RESIDUE);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    err_d   = err_q;
    dl_d    = dl_q;
    fill_d  = fill_q;
    ov_d    = 1'b0;
    sop_d   = 1'b0;
    od_d    = od_q;
    done_d  = 1'b0;
    st_d    = st_q;
    case (state_q)
      RX_IDLE: begin
        if (rx_dv_i) state_d = (rx_data_i == ETH_PREAMBLE) ? RX_PRE : RX_DROP;
      end
      RX_PRE: begin
        if (!rx_dv_i) begin
          state_d = RX_IDLE;
        end else if (rx_data_i == ETH_SFD) begin
          state_d = RX_DATA;
          crc_d   = ETH_CRC_INIT;
          len_d   = '0;
          fill_d  = '0;
          err_d   = 1'b0;
        end else if (rx_data_i != ETH_PREAMBLE) begin
          state_d = RX_DROP;
        end
      end
      RX_DATA: begin
        if (rx_dv_i) begin
          crc_d = crc_upd;
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          err_d = err_q | rxe;
          dl_d  = {dl_q[2:0], rx_data_i};
          // Four bytes held back so the FCS is never forwarded.
          if (fill_q == 3'd4) begin
            ov_d  = 1'b1;
            sop_d = (len_q == 16'd4);
            od_d  = dl_q[3];
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end else begin
          state_d      = RX_IDLE;
          done_d       = 1'b1;
          st_d.crc_ok  = crc_ok;
          st_d.err     = err_q;
          st_d.runt    = (len_q < MinLen);
          st_d.giant   = (len_q > MaxLen);
          st_d.len     = len_q;
          st_d.ok      = crc_ok & ~err_q & ~st_d.runt & ~st_d.giant;
        end
      end
      RX_DROP: begin
        if (!rx_dv_i) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk_i) begin
    if (reset_i) begin
      state_q <= RX_IDLE;
      crc_q   <= ETH_CRC_INIT;
      len_q   <= '0;
      err_q   <= 1'b0;
      dl_q    <= '0;
      fill_q  <= '0;
      ov_q    <= 1'b0;
      sop_q   <= 1'b0;
      od_q    <= '0;
      done_q  <= 1'b0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      dl_q    <= dl_d;
      fill_q  <= fill_d;
      ov_q    <= ov_d;
      sop_q   <= sop_d;
      od_q    <= od_d;
      done_q  <= done_d;
      st_q    <= st_d;
    end
  end

  assign out_valid_o    = ov_q;
  assign out_sop_o      = sop_q;
  assign out_data_o     = od_q;
  assign frame_done_o   = done_q;
  assign frame_ok_o     = st_q.ok;
  assign frame_crc_ok_o = st_q.crc_ok;
  assign frame_err_o    = st_q.err;
  assign frame_runt_o   = st_q.runt;
  assign frame_giant_o  = st_q.giant;
  assign frame_len_o    = st_q.len;

endmodule

// File: tb/tb_eth_rx_framer.sv
// Self-checking bench for eth_rx_framer: directed table, hand sequences and random frames
// checked against a frame-level reference model using a software (reflected) CRC-32.
module tb_eth_rx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv, rx_err;
  logic [7:0]  rx_data;
  logic        out_valid, out_sop, frame_done, frame_ok, frame_crc_ok;
  logic        frame_err, frame_runt, frame_giant;
  logic [7:0]  out_data;
  logic [15:0] frame_len;

  always #5 clk = ~clk;

  eth_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk_i       (clk),
    .reset_i        (reset),
    .rx_dv_i        (rx_dv),
    .rx_err_i       (rx_err),
    .rx_data_i      (rx_data),
    .out_valid_o    (out_valid),
    .out_sop_o      (out_sop),
    .out_data_o     (out_data),
    .frame_done_o   (frame_done),
    .frame_ok_o     (frame_ok),
    .frame_crc_ok_o (frame_crc_ok),
    .frame_err_o    (frame_err),
    .frame_runt_o   (frame_runt),
    .frame_giant_o  (frame_giant),
    .frame_len_o    (frame_len)
  );

  typedef struct packed {
    logic        ok;
    logic        crc_ok;
    logic        err;
    logic        runt;
    logic        giant;
    logic [15:0] len;
  } st_t;

  typedef struct {
    int pre, sfd, plen, fcs, flip, eidx;
    int nout, ndone, ok, crc, err, runt, giant, len;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  body[$];
  logic [8:0]  got_b[$], exp_b[$];
  st_t         got_s[$], exp_s[$];
  vec_t        vt[12];

  // Monitor: every forwarded byte and every status pulse, in arrival order.
  always @(negedge clk) begin
    if (out_valid)  got_b.push_back({out_sop, out_data});
    if (frame_done) got_s.push_back({frame_ok, frame_crc_ok, frame_err, frame_runt, frame_giant, frame_len});
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      c = c ^ {24'd0, body[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_body(input int plen, input int fcs, input int flip);
    logic [31:0] f;
    body.delete();
    for (int i = 0; i < plen; i++) body.push_back(8'($urandom));
    if (fcs != 0) begin
      f = ~crc_ref();
      for (int i = 0; i < 4; i++) body.push_back(f[8*i +: 8]);
    end
    if (flip >= 0) body[flip] = body[flip] ^ 8'h01;
  endtask

  // Reference: everything but the last four body bytes is forwarded; status from whole body.
  task automatic model_frame(input bit ferr);
    st_t s;
    int  n = body.size();
    for (int i = 0; i + 4 < n; i++) exp_b.push_back({(i == 0), body[i]});
    s.len    = (n > 65535) ? 16'hFFFF : 16'(n);
    s.crc_ok = (crc_ref() == 32'hDEBB20E3);
    s.err    = ferr;
    s.runt   = (n < 64);
    s.giant  = (n > 1518);
    s.ok     = s.crc_ok && !ferr && !s.runt && !s.giant;
    exp_s.push_back(s);
  endtask

  task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv; rx_err = er; rx_data = d;
    @(negedge clk);
  endtask

  task automatic send_frame(input int pre, input logic [7:0] sfd, input int eidx, input int gap);
    for (int i = 0; i < pre; i++) cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, sfd);
    for (int i = 0; i < body.size(); i++) cyc(1'b1, (i == eidx) ? 1'b0 : 1'b1, body[i]);
    for (int i = 0; i < gap; i++) cyc(1'b0, 1'($urandom), 8'($urandom));
    if (sfd == 8'hD5 && pre >= 1) model_frame(eidx >= 0 && eidx < body.size());
  endtask

  task automatic clear_q();
    got_b.delete(); exp_b.delete(); got_s.delete(); exp_s.delete();
  endtask

  task automatic compare_q(input string tag);
    int bad = -1;
    #1;
    chk({tag, " byte_count"}, got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      if (bad < 0 && got_b[i] != exp_b[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s byte_stream: at %0d got %h expected %h", tag, bad, got_b[bad], exp_b[bad]);
    end
    chk({tag, " status_count"}, got_s.size(), exp_s.size());
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
      tests++;
      if (got_s[i] != exp_s[i]) begin
        fails++;
        $display("FAIL %s status[%0d]: got %h expected %h", tag, i, got_s[i], exp_s[i]);
      end
    end
    clear_q();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, int'({out_valid, out_sop, out_data, frame_done, frame_ok, frame_crc_ok,
                    frame_err, frame_runt, frame_giant, frame_len}), 0);
  endtask

  initial begin
    int pre, plen, fcs, flip, eidx;
    logic [7:0] sfd;

    //        pre  sfd    plen fcs flip eidx | nout ndone ok crc err runt giant len
    vt[0]  = '{8, 'hD5,   60, 1,  -1, -1,     60,   1,   1,  1,  0,  0,   0,    64};
    vt[1]  = '{8, 'hD5,   60, 1,  10, -1,     60,   1,   0,  0,  0,  0,   0,    64};
    vt[2]  = '{8, 'hD5,   60, 1,  -1, 20,     60,   1,   0,  1,  1,  0,   0,    64};
    vt[3]  = '{8, 'hD5,    3, 0,  -1, -1,      0,   1,   0, -1,  0,  1,   0,     3};
    vt[4]  = '{8, 'hD5, 1596, 1,  -1, -1,   1596,   1,   0,  1,  0,  0,   1,  1600};
    vt[5]  = '{2, 'hA5,   70, 0,  -1, -1,      0,   0,   0,  0,  0,  0,   0,     0};
    vt[6]  = '{7, 'hD5,   60, 1,  -1, -1,     60,   1,   1,  1,  0,  0,   0,    64};
    vt[7]  = '{1, 'hD5,   59, 1,  -1, -1,     59,   1,   0,  1,  0,  1,   0,    63};
    vt[8]  = '{8, 'hD5, 1514, 1,  -1, -1,   1514,   1,   1,  1,  0,  0,   0,  1518};
    vt[9]  = '{8, 'hD5, 1515, 1,  -1, -1,   1515,   1,   0,  1,  0,  0,   1,  1519};
    vt[10] = '{8, 'hD5,    0, 0,  -1, -1,      0,   1,   0,  0,  0,  1,   0,     0};
    vt[11] = '{8, 'hD5,    1, 1,  -1, -1,      1,   1,   0,  1,  0,  1,   0,     5};

    reset = 1'b1; rx_dv = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_state");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    chk_outputs_zero("idle_after_reset");
    #1 clear_q();

    foreach (vt[k]) begin
      build_body(vt[k].plen, vt[k].fcs, vt[k].flip);
      send_frame(vt[k].pre, 8'(vt[k].sfd), vt[k].eidx, 4);
      #1;
      chk($sformatf("vec%0d nout", k), got_b.size(), vt[k].nout);
      chk($sformatf("vec%0d ndone", k), got_s.size(), vt[k].ndone);
      if (vt[k].nout > 0 && got_b.size() > 0) chk($sformatf("vec%0d sop", k), int'(got_b[0][8]), 1);
      if (vt[k].ndone > 0 && got_s.size() > 0) begin
        chk($sformatf("vec%0d ok", k),    int'(got_s[0].ok),    vt[k].ok);
        chk($sformatf("vec%0d err", k),   int'(got_s[0].err),   vt[k].err);
        chk($sformatf("vec%0d runt", k),  int'(got_s[0].runt),  vt[k].runt);
        chk($sformatf("vec%0d giant", k), int'(got_s[0].giant), vt[k].giant);
        chk($sformatf("vec%0d len", k),   int'(got_s[0].len),   vt[k].len);
        if (vt[k].crc >= 0) chk($sformatf("vec%0d crc_ok", k), int'(got_s[0].crc_ok), vt[k].crc);
      end
      compare_q($sformatf("vec%0d", k));
    end

    // Back-to-back frames with a single idle cycle between them.
    build_body(60, 1, -1);
    send_frame(8, 8'hD5, -1, 1);
    build_body(70, 1, -1);
    send_frame(3, 8'hD5, -1, 4);
    compare_q("back2back");

    // Reset at byte 30; the rest of that frame must be dropped.
    build_body(60, 1, -1);
    body[30] = 8'hA0; body[31] = 8'hA1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, body[i]);
    reset = 1'b1;
    cyc(1'b1, 1'b1, body[30]);
    reset = 1'b0;
    chk_outputs_zero("midframe_reset_outputs");
    #1 clear_q();
    for (int i = 31; i < body.size(); i++) cyc(1'b1, 1'b1, body[i]);
    cyc(1'b0, 1'b0, 8'h00);
    build_body(60, 1, -1);
    send_frame(8, 8'hD5, -1, 4);
    #1;
    chk("after_reset ok", (got_s.size() == 1) ? int'(got_s[0].ok) : -1, 1);
    compare_q("after_reset");

    // Random frames against the reference model.
    for (int k = 0; k < 30; k++) begin
      pre  = int'($urandom_range(1, 8));
      sfd  = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'hD5;
      plen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1500, 1520)) : int'($urandom_range(0, 100));
      fcs  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      flip = -1;
      if ($urandom_range(0, 4) == 0 && plen > 0) flip = int'($urandom_range(0, plen - 1));
      eidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, plen + 3)) : -1;
      build_body(plen, fcs, flip);
      send_frame(pre, sfd, eidx, int'($urandom_range(1, 3)));
    end
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    compare_q("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
